// File: rtl/bram_load.sv
// Bit-serial BRAM loader: unpacks PS bytes (toggle handshake) into 1-bit writes over addra_begin..addra_end.
// Optional macro BRAM_LOAD_MSB_FIRST_EN selects MSB-first bit order (default LSB first).
module bram_load #(
    parameter int ADDR_WIDTH_3 = 12,
    parameter int ADDR_BEGIN   = 3,
    parameter int ADDR_END     = 103
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    im_start,
    input  logic                    im_work,
    input  logic [7:0]              im_data,
    output logic                    om_start,
    output logic                    om_work,
    output logic                    om_data,
    output logic [ADDR_WIDTH_3-1:0] addra,
    output logic                    dina,
    output logic                    wea,
    input  logic [ADDR_WIDTH_3-1:0] addra_begin,
    input  logic [ADDR_WIDTH_3-1:0] addra_end
);

    // Wrapper defaults must be addressable in the configured window
    if (ADDR_BEGIN < 0 || ADDR_BEGIN >= (1 << ADDR_WIDTH_3) ||
        ADDR_END < 0 || ADDR_END >= (1 << ADDR_WIDTH_3)) begin : g_bad_default
        $error("bram_load: default window outside address range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_start_d;
    logic [ADDR_WIDTH_3-1:0] r_addr;
    logic [ADDR_WIDTH_3-1:0] r_end;
    logic [7:0]              r_byte;
    logic [2:0]              r_bit_cnt;
    logic                    r_om_start;
    logic                    r_om_work;
    logic                    r_om_data;
    logic [ADDR_WIDTH_3-1:0] r_addra;
    logic                    r_dina;
    logic                    r_wea;
    logic                    w_bit;

`ifdef BRAM_LOAD_MSB_FIRST_EN
    assign w_bit = r_byte[3'd7 - r_bit_cnt];
`else
    assign w_bit = r_byte[r_bit_cnt];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start_d  <= 1'b0;
            r_addr     <= '0;
            r_end      <= '0;
            r_byte     <= '0;
            r_bit_cnt  <= '0;
            r_om_start <= 1'b0;
            r_om_work  <= 1'b0;
            r_om_data  <= 1'b0;
            r_addra    <= '0;
            r_dina     <= 1'b0;
            r_wea      <= 1'b0;
        end else begin
            r_start_d <= im_start;
            case (r_state)
                S_IDLE: begin
                    r_wea <= 1'b0;
                    if (im_start && !r_start_d) begin
                        r_addr    <= addra_begin;
                        r_end     <= addra_end;
                        r_om_data <= 1'b1;
                        r_state   <= (addra_end < addra_begin) ? S_DONE : S_WAIT_BYTE;
                    end
                end
                S_WAIT_BYTE: begin
                    r_wea <= 1'b0;
                    if (!im_start) begin
                        r_om_data  <= 1'b0;
                        r_om_start <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (im_work != r_om_work) begin
                        r_byte    <= im_data;
                        r_bit_cnt <= '0;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!im_start) begin
                        // Abort leaves the ack toggle untouched so the byte is not acknowledged
                        r_wea      <= 1'b0;
                        r_om_data  <= 1'b0;
                        r_om_start <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wea   <= 1'b1;
                        r_addra <= r_addr;
                        r_dina  <= w_bit;
                        if (r_addr == r_end) begin
                            r_om_work <= im_work;
                            r_state   <= S_DONE;
                        end else begin
                            r_addr <= r_addr + ADDR_WIDTH_3'(1);
                            if (r_bit_cnt == 3'd7) begin
                                r_om_work <= im_work;
                                r_state   <= S_WAIT_BYTE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_wea     <= 1'b0;
                    r_om_data <= 1'b0;
                    if (im_start) begin
                        r_om_start <= 1'b1;
                    end else begin
                        r_om_start <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign om_start = r_om_start;
    assign om_work  = r_om_work;
    assign om_data  = r_om_data;
    assign addra    = r_addra;
    assign dina     = r_dina;
    assign wea      = r_wea;

endmodule
